jesd204b_scrambler: RTL
=======================

// Module: jesd204b_scrambler
// PURPOSE
//  JESD204B TX-side self-synchronous scrambler, polynomial 1 + x^14 + x^15, one lane.
//  Sits between the TX transport layer (framed octets) and the 8b/10b encoder.
//  Processes DATA_WIDTH bits per clock with a valid/ready handshake and one output register.
//  Bitstream is the exact inverse of jesd204b_descrambler when both start from the same state.
// PARAMETERS
//  DATA_WIDTH  64             word width in bits; multiple of 8, >= 16
//  INIT_STATE  15'h7F80       scrambler state after reset / while disabled (bits 14:7 = 1)
// PORTS
//  clk        in   1           clock, all logic rising-edge
//  reset      in   1           reset, synchronous, active-high
//  en         in   1           1 = scramble, 0 = bypass (sampled with each accepted word)
//  in_data    in   DATA_WIDTH  unscrambled word; bit DATA_WIDTH-1 is first in time
//  in_valid   in   1           in_data valid
//  in_ready   out  1           block can accept a word this cycle
//  out_data   out  DATA_WIDTH  scrambled word, same bit order as in_data
//  out_valid  out  1           out_data valid
//  out_ready  in   1           downstream accepts out_data
// BEHAVIOUR
//  Reset: out_data=0, out_valid=0, state=INIT_STATE; in_ready=1 in the cycle after reset falls.
//  Accept = in_valid & in_ready; in_ready = !out_valid | out_ready (combinational, no skid).
//  Latency 1 clk: word accepted at edge N appears on out_data with out_valid=1 after edge N.
//  out_data/out_valid hold while out_valid & !out_ready; in_data is ignored when not accepted.
//  Scramble (en=1), st = 15-bit state, st[0] = newest, for i = DATA_WIDTH-1 down to 0:
//    s = in_data[i] ^ st[14] ^ st[13]; out_data[i] = s; st = {st[13:0], s}
//    Feedback uses scrambled bits, not input bits; final st is registered on accept.
//  Bypass (en=0 on an accepted word): out_data = in_data; state reloads INIT_STATE.
//  en=0 with no accept: state is still reloaded to INIT_STATE, so the next enabled word starts from INIT_STATE.
//  en=1 with no accept: state holds, so back-pressure stalls never corrupt the sequence.
//  Accept and drain in the same cycle: both occur, so full throughput is 1 word/clk.
//  Reset asserted mid-stream: the pending output word is dropped and the state is reinitialised on that edge.
//  No per-word exemption: the first word after enable is scrambled (the RX seeds from the line).
// CONFIGURATION
//  JESD204B_SCR_SEED_LOAD_EN defined: adds ports seed_load (in,1) and seed (in,15).
//    When seed_load=1, state <= seed on that edge, with priority over the en=0 reload.
//    When an accept happens in the same cycle, the word uses the old state; the seed replaces the result.
//  Not defined: no seed ports; state changes only by reset, en=0 reload, or accepted words.
// TESTING
//  T1 reset, en=0, word 64'h0123_4567_89AB_CDEF -> same value out 1 clk later, out_valid=1.
//  T2 reset, en=1, all-zero input word -> out_data[63:40] = 24'h010006.
//  T3 1000 random words, en=1, through a reference descrambler model -> original data recovered bit-exact.
//  T4 random out_ready back-pressure (50%) on T3 stream -> identical output sequence, no drop/dup.
//  T5 en 1->0->1 between words -> word after re-enable matches T2 pattern for zero input.
//  T6 reset pulse mid-stream with out_valid=1 -> out_valid=0, out_data=0, next output per T2.

Source files
------------

// File: rtl/jesd204b_scrambler_if.sv
// ---------------------------------------------------------------------------------------------
// jesd204b_scrambler_if
// Purpose : groups the streaming signals of the JESD204B lane scrambler into one bundle.
// Signals :
//   en         1 = scramble, 0 = bypass (sampled with each accepted word)
//   in_data    unscrambled word, bit DATA_WIDTH-1 first in time
//   in_valid   in_data valid
//   in_ready   scrambler can accept a word this cycle
//   out_data   scrambled word, same bit order as in_data
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data
// Modports:
//   master  drives the input side and out_ready (transport layer / testbench)
//   slave   the scrambler itself
// ---------------------------------------------------------------------------------------------
interface jesd204b_scrambler_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  en;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output en,
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  en,
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/jesd204b_scrambler.sv
// ---------------------------------------------------------------------------------------------
// jesd204b_scrambler
// Purpose : JESD204B TX self-synchronous scrambler, polynomial 1 + x^14 + x^15, one lane.
//           Sits between the TX transport layer and the 8b/10b encoder. DATA_WIDTH bits per
//           clock, valid/ready handshake, one output register (latency 1 clk).
// Parameters:
//   DATA_WIDTH  word width in bits, multiple of 8 and >= 16
//   INIT_STATE  scrambler state after reset and while disabled
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high reset
//   bus        jesd204b_scrambler_if.slave (en, in_*, out_* handshake)
//   seed_load  (JESD204B_SCR_SEED_LOAD_EN only) load seed into the state on this edge
//   seed       (JESD204B_SCR_SEED_LOAD_EN only) 15-bit state value to load
// Configuration:
//   JESD204B_SCR_SEED_LOAD_EN  when defined, adds seed_load/seed ports. Without it the state
//                              changes only through reset, the en=0 reload or accepted words.
// ---------------------------------------------------------------------------------------------
module jesd204b_scrambler #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter logic [14:0] INIT_STATE = 15'h7F80
) (
    input  logic                     clk,
    input  logic                     reset,
    jesd204b_scrambler_if.slave      bus
`ifdef JESD204B_SCR_SEED_LOAD_EN
    ,
    input  logic                     seed_load,
    input  logic [14:0]              seed
`endif
);

    // Scrambles one word MSB-first. The state shifts in the scrambled bit (self-synchronous),
    // so the receiver can rebuild the state from the line alone. Returns {data, final state}.
    function automatic logic [DATA_WIDTH+14:0] scramble_word(
        input logic [DATA_WIDTH-1:0] data,
        input logic [14:0]           st_in
    );
        logic [14:0]           st;
        logic [DATA_WIDTH-1:0] q;
        logic                  s;
        st = st_in;
        q  = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            s    = data[i] ^ st[14] ^ st[13];
            q[i] = s;
            st   = {st[13:0], s};
        end
        return {q, st};
    endfunction

    logic [14:0]           r_state;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;

    logic [DATA_WIDTH-1:0] w_scr_data;
    logic [14:0]           w_scr_state;
    logic                  w_in_ready;
    logic                  w_accept;
    logic [14:0]           w_state_d;
    logic [DATA_WIDTH-1:0] w_out_data_d;
    logic                  w_out_valid_d;

    // No skid buffer: ready only when the output register is empty or draining this cycle.
    assign w_in_ready    = !r_out_valid || bus.out_ready;
    assign w_accept      = bus.in_valid && w_in_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;

    always_comb begin
        {w_scr_data, w_scr_state} = scramble_word(bus.in_data, r_state);
    end

    // State update. Holding while en=1 and idle keeps the sequence intact across stalls;
    // en=0 always reloads so the next enabled word starts from a known state.
    always_comb begin
        w_state_d = r_state;
        if (w_accept) begin
            w_state_d = bus.en ? w_scr_state : INIT_STATE;
        end else if (!bus.en) begin
            w_state_d = INIT_STATE;
        end
`ifdef JESD204B_SCR_SEED_LOAD_EN
        // Seed wins over everything; a word accepted on this edge already used the old state.
        if (seed_load) begin
            w_state_d = seed;
        end
`endif
    end

    // Output register: load on accept (which may coincide with a drain), clear valid on drain.
    always_comb begin
        w_out_data_d  = r_out_data;
        w_out_valid_d = r_out_valid;
        if (w_accept) begin
            w_out_data_d  = bus.en ? w_scr_data : bus.in_data;
            w_out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            w_out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= INIT_STATE;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_out_data  <= w_out_data_d;
            r_out_valid <= w_out_valid_d;
        end
    end

endmodule
